// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction prefetch queue between the IFU and RegDecode.
// Holds {instruction, PC+4} pairs in FIFO order and presents the oldest pair
// to decode, or a NOP (all zeros) when empty. A flush discards every entry.
// Optional feature macro: FBUF_BYPASS_EN (empty-queue combinational bypass).
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [31:0]   in_instr,
  input  logic [31:0]   in_pc4,
  output logic          in_ready,
  input  logic          flush,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc4,
  output logic [AW:0]   count,
  output logic          ovf_err
);

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc4_mem   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count_q;
  logic [AW:0]   count_next;
  logic          ovf_q;
  occ_e          occ;
  logic          head_valid;
  logic          push;
  logic          pop;
`ifdef FBUF_BYPASS_EN
  logic          bypass;
`endif

  assign count   = count_q;
  assign ovf_err = ovf_q;

  // Occupancy state decoded from the registered count.
  always_comb begin
    occ = OCC_PARTIAL;
    if (count_q == '0) begin
      occ = OCC_EMPTY;
    end else if (count_q == FULL_COUNT) begin
      occ = OCC_FULL;
    end
  end

  assign head_valid = (occ != OCC_EMPTY);
  assign in_ready   = (occ != OCC_FULL);

  // Push/pop qualification; flush suppresses both.
  always_comb begin
    pop  = out_ready & head_valid & ~flush;
    push = in_valid & in_ready & ~flush;
`ifdef FBUF_BYPASS_EN
    bypass = (occ == OCC_EMPTY) & in_valid & ~flush;
    // A bypassed word taken by decode in the same cycle is never stored.
    if (bypass && out_ready) begin
      push = 1'b0;
    end
`endif
    count_next = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
  end

  // Head presentation: storage head qualified by occupancy, NOP otherwise.
  always_comb begin
    out_valid = head_valid;
    out_instr = head_valid ? instr_mem[rd_ptr] : '0;
    out_pc4   = head_valid ? pc4_mem[rd_ptr]   : '0;
`ifdef FBUF_BYPASS_EN
    if (bypass) begin
      out_valid = 1'b1;
      out_instr = in_instr;
      out_pc4   = in_pc4;
    end
`endif
  end

  // Entry storage; contents need no reset since occupancy qualifies reads.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem[wr_ptr] <= in_instr;
      pc4_mem[wr_ptr]   <= in_pc4;
    end
  end

  // Pointers, occupancy count and sticky overflow flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (in_valid && !in_ready) begin
        ovf_q <= 1'b1;
      end
      if (flush) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count_q <= count_next;
      end
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: table-driven directed test of fetch_buffer, plus
// hand-written sequences for async reset mid-operation and head latency.
module tb_fetch_buffer;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc4;
  logic        in_ready;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc4;
  logic [2:0]  count;
  logic        ovf_err;

  int checks = 0;
  int errors = 0;
  int cur_row = -1;

  fetch_buffer #(.DEPTH(4), .AW(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc4    (in_pc4),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc4   (out_pc4),
    .count     (count),
    .ovf_err   (ovf_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst_before;
    logic        iv;
    logic [31:0] ii;
    logic [31:0] ip;
    logic        fl;
    logic        ordy;
    logic [2:0]  e_cnt;
    logic        e_ov;
    logic [31:0] e_oi;
    logic [31:0] e_op;
    logic        e_ir;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic rb, input logic iv, input logic [31:0] ii,
                             input logic [31:0] ip, input logic fl, input logic ordy,
                             input logic [2:0] ec, input logic eov, input logic [31:0] eoi,
                             input logic [31:0] eop, input logic eir, input logic eovf);
    vec_t r;
    r.rst_before = rb; r.iv = iv; r.ii = ii; r.ip = ip; r.fl = fl; r.ordy = ordy;
    r.e_cnt = ec; r.e_ov = eov; r.e_oi = eoi; r.e_op = eop; r.e_ir = eir; r.e_ovf = eovf;
    return r;
  endfunction

  function automatic logic [31:0] w(input int k);
    return 32'h0000_1000 + 32'(k);
  endfunction

  function automatic logic [31:0] p(input int k);
    return 32'h0000_0100 + 32'(4 * k);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row=%0d actual=%h required=%h", nm, cur_row, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_instr = '0; in_pc4 = '0; flush = 1'b0; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    idle_inputs();
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [2:0]  ec;
    logic        eov;
    logic [31:0] eoi;
    logic [31:0] eop;

    // Fill, overflow (plus blocked push while full), drain to NOP.
    tbl.push_back(v(0, 1, 32'h11111111, 32'd4,  0, 0, 3'd0, 0, 32'h0,        32'd0,  1, 0));
    tbl.push_back(v(0, 1, 32'h22222222, 32'd8,  0, 0, 3'd1, 1, 32'h11111111, 32'd4,  1, 0));
    tbl.push_back(v(0, 1, 32'h33333333, 32'd12, 0, 0, 3'd2, 1, 32'h11111111, 32'd4,  1, 0));
    tbl.push_back(v(0, 1, 32'h44444444, 32'd16, 0, 0, 3'd3, 1, 32'h11111111, 32'd4,  1, 0));
    tbl.push_back(v(0, 1, 32'h55555555, 32'd20, 0, 0, 3'd4, 1, 32'h11111111, 32'd4,  0, 0));
    tbl.push_back(v(0, 1, 32'h66666666, 32'd24, 0, 1, 3'd4, 1, 32'h11111111, 32'd4,  0, 1));
    tbl.push_back(v(0, 0, 32'h0,        32'd0,  0, 1, 3'd3, 1, 32'h22222222, 32'd8,  1, 1));
    tbl.push_back(v(0, 0, 32'h0,        32'd0,  0, 1, 3'd2, 1, 32'h33333333, 32'd12, 1, 1));
    tbl.push_back(v(0, 0, 32'h0,        32'd0,  0, 1, 3'd1, 1, 32'h44444444, 32'd16, 1, 1));
    tbl.push_back(v(0, 0, 32'h0,        32'd0,  0, 0, 3'd0, 0, 32'h0,        32'd0,  1, 1));
    // Wrap: steady push+pop at count=2 for 10 cycles after a fresh reset.
    tbl.push_back(v(1, 1, w(1), p(1), 0, 0, 3'd0, 0, 32'h0, 32'd0, 1, 0));
    tbl.push_back(v(0, 1, w(2), p(2), 0, 0, 3'd1, 1, w(1),  p(1),  1, 0));
    for (int k = 3; k <= 12; k++) begin
      tbl.push_back(v(0, 1, w(k), p(k), 0, 1, 3'd2, 1, w(k - 2), p(k - 2), 1, 0));
    end
    tbl.push_back(v(0, 0, 32'h0, 32'd0, 0, 1, 3'd2, 1, w(11), p(11), 1, 0));
    tbl.push_back(v(0, 0, 32'h0, 32'd0, 0, 1, 3'd1, 1, w(12), p(12), 1, 0));
    tbl.push_back(v(0, 0, 32'h0, 32'd0, 0, 0, 3'd0, 0, 32'h0, 32'd0, 1, 0));
    // Flush at count=3 with a concurrent push and pop request.
    tbl.push_back(v(0, 1, 32'hF0000001, 32'h200, 0, 0, 3'd0, 0, 32'h0,        32'h0,   1, 0));
    tbl.push_back(v(0, 1, 32'hF0000002, 32'h204, 0, 0, 3'd1, 1, 32'hF0000001, 32'h200, 1, 0));
    tbl.push_back(v(0, 1, 32'hF0000003, 32'h208, 0, 0, 3'd2, 1, 32'hF0000001, 32'h200, 1, 0));
    tbl.push_back(v(0, 1, 32'hAAAAAAAA, 32'h20C, 1, 1, 3'd3, 1, 32'hF0000001, 32'h200, 1, 0));
    tbl.push_back(v(0, 0, 32'h0,        32'h0,   0, 1, 3'd0, 0, 32'h0,        32'h0,   1, 0));
    tbl.push_back(v(0, 0, 32'h0,        32'h0,   0, 1, 3'd0, 0, 32'h0,        32'h0,   1, 0));

    // Reset held low, then released.
    idle_inputs();
    reset = 1'b0;
    #3;
    chk("rst_hold_count", 32'(count), 32'd0);
    chk("rst_hold_out_valid", 32'(out_valid), 32'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc4", out_pc4, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_ovf_err", 32'(ovf_err), 32'd0);
    @(posedge clock); #1;

    // Table-driven vectors: inputs at posedge+1, outputs sampled at posedge+3.
    for (int i = 0; i < tbl.size(); i++) begin
      cur_row = i;
      if (tbl[i].rst_before) do_reset();
      in_valid  = tbl[i].iv;
      in_instr  = tbl[i].ii;
      in_pc4    = tbl[i].ip;
      flush     = tbl[i].fl;
      out_ready = tbl[i].ordy;
      ec = tbl[i].e_cnt; eov = tbl[i].e_ov; eoi = tbl[i].e_oi; eop = tbl[i].e_op;
`ifdef FBUF_BYPASS_EN
      // An empty queue forwards the incoming word to the head combinationally.
      if (ec == 3'd0 && tbl[i].iv && !tbl[i].fl) begin
        eov = 1'b1; eoi = tbl[i].ii; eop = tbl[i].ip;
      end
`endif
      #2;
      chk("count", 32'(count), 32'(ec));
      chk("out_valid", 32'(out_valid), 32'(eov));
      chk("out_instr", out_instr, eoi);
      chk("out_pc4", out_pc4, eop);
      chk("in_ready", 32'(in_ready), 32'(tbl[i].e_ir));
      chk("ovf_err", 32'(ovf_err), 32'(tbl[i].e_ovf));
      @(posedge clock); #1;
    end

    // Asynchronous reset mid-operation discards entries without a clock edge.
    cur_row = 1000;
    idle_inputs();
    in_valid = 1'b1; in_instr = 32'h12345678; in_pc4 = 32'h300;
    @(posedge clock); #1;
    in_instr = 32'h9ABCDEF0; in_pc4 = 32'h304;
    @(posedge clock); #1;
    idle_inputs();
    #2;
    chk("async_pre_count", 32'(count), 32'd2);
    chk("async_pre_head", out_instr, 32'h12345678);
    #1;
    reset = 1'b0;
    #1;
    chk("async_count", 32'(count), 32'd0);
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_out_instr", out_instr, 32'h0);
    chk("async_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;

    // Head latency from empty with decode ready.
    cur_row = 2000;
    in_valid = 1'b1; in_instr = 32'h8C220004; in_pc4 = 32'h00400008; out_ready = 1'b1;
    #2;
    chk("lat0_count", 32'(count), 32'd0);
`ifdef FBUF_BYPASS_EN
    chk("lat0_out_valid", 32'(out_valid), 32'd1);
    chk("lat0_out_instr", out_instr, 32'h8C220004);
    chk("lat0_out_pc4", out_pc4, 32'h00400008);
`else
    chk("lat0_out_valid", 32'(out_valid), 32'd0);
    chk("lat0_out_instr", out_instr, 32'h0);
`endif
    @(posedge clock); #1;
    idle_inputs();
    #2;
`ifdef FBUF_BYPASS_EN
    chk("lat1_count", 32'(count), 32'd0);
    chk("lat1_out_valid", 32'(out_valid), 32'd0);
    chk("lat1_out_instr", out_instr, 32'h0);
`else
    chk("lat1_count", 32'(count), 32'd1);
    chk("lat1_out_valid", 32'(out_valid), 32'd1);
    chk("lat1_out_instr", out_instr, 32'h8C220004);
    chk("lat1_out_pc4", out_pc4, 32'h00400008);
`endif
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    #2;
    chk("lat2_count", 32'(count), 32'd0);
    chk("lat2_out_valid", 32'(out_valid), 32'd0);
    chk("lat2_ovf_err", 32'(ovf_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
